// File: rtl/maxpool_stream_if.sv
// Streaming handshake bundle for maxpool_stream: sample input channel and
// pooled output channel, each a valid/ready pair.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

interface maxpool_stream_if #(
  parameter int DATA_W = `INTERNAL_BITS
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Producer/consumer side (drives samples, accepts pooled results)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Pooling block side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 2x2 / stride-2 signed max pooling over a raster
// frame of up to MAX_DIM x MAX_DIM samples. Even rows fold column pairs into
// a half-width line buffer; odd rows combine with it to emit one result.
// Optional feature macro: MAXPOOL_RELU_EN (fused ReLU on accepted samples).
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module maxpool_stream #(
  parameter int DATA_W  = `INTERNAL_BITS,
  parameter int MAX_DIM = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] cfg_rows,
  input  logic [6:0] cfg_cols,
  maxpool_stream_if.slave bus,
  output logic       busy,
  output logic       done,
  output logic       cfg_err
);

  localparam int         LB_DEPTH  = MAX_DIM / 2;
  localparam int         LB_AW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [6:0] MAX_DIM_V = 7'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [6:0]               rows_q, cols_q;
  logic [6:0]               row_q, col_q;
  logic signed [DATA_W-1:0] pair_q;
  logic signed [DATA_W-1:0] out_q;
  logic                     ov_q;
  logic                     cfg_err_q;
  logic signed [DATA_W-1:0] linebuf [LB_DEPTH];

  logic                     cfg_ok;
  logic                     start_ok;
  logic                     in_ready_w;
  logic                     acc;
  logic                     xfer;
  logic                     last_col;
  logic                     last_in;
  logic [LB_AW-1:0]         lb_idx;
  logic signed [DATA_W-1:0] samp;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] quad_max;

  // Configuration legality: even, nonzero, within MAX_DIM.
  always_comb begin
    cfg_ok   = (cfg_rows != '0) && !cfg_rows[0] && (cfg_rows <= MAX_DIM_V) &&
               (cfg_cols != '0) && !cfg_cols[0] && (cfg_cols <= MAX_DIM_V);
    start_ok = (state_q == IDLE) && start && cfg_ok;
  end

  // Handshake qualifiers and raster-position decode.
  always_comb begin
    acc      = bus.in_valid && in_ready_w;
    xfer     = ov_q && bus.out_ready;
    last_col = (col_q == cols_q - 7'd1);
    last_in  = last_col && (row_q == rows_q - 7'd1);
    lb_idx   = col_q[LB_AW:1];
  end

  // Sample conditioning and the pairwise / quad max datapath.
  always_comb begin
`ifdef MAXPOOL_RELU_EN
    samp = bus.in_data[DATA_W-1] ? '0 : $signed(bus.in_data);
`else
    samp = $signed(bus.in_data);
`endif
    pair_max = (pair_q > samp) ? pair_q : samp;
    lb_rd    = linebuf[lb_idx];
    quad_max = (lb_rd > pair_max) ? lb_rd : pair_max;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (acc && last_in) state_d = FLUSH;
      FLUSH:   if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: input stalls only while a result is pending and blocked.
  always_comb begin
    busy       = (state_q == RUN);
    in_ready_w = (state_q == RUN) && !(ov_q && !bus.out_ready);
    done       = (state_q == FLUSH) && xfer;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = out_q;
  assign cfg_err       = cfg_err_q;

  // Frame counters, pair register and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pair_q    <= '0;
      out_q     <= '0;
      ov_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && start && !cfg_ok;
      if (start_ok) begin
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
        row_q  <= '0;
        col_q  <= '0;
      end
      if (acc) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 7'd1;
        end else begin
          col_q <= col_q + 7'd1;
        end
        if (!col_q[0]) pair_q <= samp;
      end
      // A new result overrides the clear of one being accepted on the same edge.
      if (acc && row_q[0] && col_q[0]) begin
        out_q <= quad_max;
        ov_q  <= 1'b1;
      end else if (xfer) begin
        ov_q  <= 1'b0;
      end
    end
  end

  // Even-row column-pair maxima, consumed by the following odd row.
  always_ff @(posedge clk) begin
    if (acc && !row_q[0] && col_q[0]) linebuf[lb_idx] <= pair_max;
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: small hand-checked frames, backpressure,
// illegal configuration, mid-frame reset, and a full 64x64 randomised frame.
module tb_maxpool_stream;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] cfg_rows;
  logic [6:0] cfg_cols;
  logic       busy;
  logic       done;
  logic       cfg_err;

  maxpool_stream_if #(.DATA_W(32)) bus ();

  maxpool_stream #(.DATA_W(32), .MAX_DIM(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_rows (cfg_rows),
    .cfg_cols (cfg_cols),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pix     [4096];
  int exp_arr [1024];
  int nexp;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int rl(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Software 2x2 / stride-2 max over pix[] for a rows x cols frame.
  task automatic build_model(input int rows, input int cols);
    nexp = 0;
    for (int r = 0; r < rows; r += 2)
      for (int c = 0; c < cols; c += 2) begin
        exp_arr[nexp] = mx(mx(rl(pix[r*cols+c]),     rl(pix[r*cols+c+1])),
                           mx(rl(pix[(r+1)*cols+c]), rl(pix[(r+1)*cols+c+1])));
        nexp++;
      end
  endtask

  task automatic do_start(input int rows, input int cols);
    @(negedge clk);
    start    = 1'b1;
    cfg_rows = 7'(rows);
    cfg_cols = 7'(cols);
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Streams pix[0..rows*cols-1] and checks outputs against exp_arr[0..nexp-1].
  task automatic run_frame(input int rows, input int cols, input int gap_in,
                           input int gap_out, input bit stall, input string tag);
    int n;
    int in_idx;
    int out_idx;
    int done_cnt;
    int cyc;
    bit stalled;
    bit acc;
    bit xfer;
    n = rows * cols; in_idx = 0; out_idx = 0; done_cnt = 0; cyc = 0; stalled = 0;
    do_start(rows, cols);
    #1 chk({tag, "_busy"}, busy, 1);
    while ((in_idx < n || out_idx < nexp) && cyc < 30000) begin
      @(negedge clk);
      if (stall && !stalled && bus.out_valid) begin
        stalled = 1;
        for (int k = 0; k < 5; k++) begin
          bus.out_ready = 1'b0;
          bus.in_valid  = (in_idx < n);
          bus.in_data   = pix[in_idx];
          #1;
          chk({tag, "_stall_rdy"}, bus.in_ready, 0);
          chk({tag, "_stall_dat"}, bus.out_data, exp_arr[out_idx]);
          @(posedge clk);
          @(negedge clk);
        end
      end
      bus.in_valid  = (in_idx < n) && ($urandom_range(99) >= 32'(gap_in));
      bus.in_data   = bus.in_valid ? pix[in_idx] : $urandom;
      bus.out_ready = ($urandom_range(99) >= 32'(gap_out));
      #1;
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (xfer) begin
        if (out_idx < nexp) chk($sformatf("%s_out%0d", tag, out_idx), bus.out_data, exp_arr[out_idx]);
        out_idx++;
        if (out_idx == nexp) chk({tag, "_done_last"}, done, 1);
      end
      if (done) done_cnt++;
      @(posedge clk);
      if (acc) in_idx++;
      cyc++;
    end
    if (cyc >= 30000) chk({tag, "_timeout"}, cyc, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk({tag, "_no_extra"}, bus.out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_nout"}, out_idx, nexp);
    chk({tag, "_ndone"}, done_cnt, 1);
  endtask

  initial begin
    int bad_rows [3];
    int bad_cols [3];
    rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data",  bus.out_data,  0);
    chk("rst_busy",      busy,          0);
    chk("rst_done",      done,          0);
    chk("rst_cfg_err",   cfg_err,       0);
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 ramp: maxima of each quadrant are its bottom-right samples.
    for (int i = 0; i < 16; i++) pix[i] = i;
    exp_arr[0] = 5; exp_arr[1] = 7; exp_arr[2] = 13; exp_arr[3] = 15; nexp = 4;
    run_frame(4, 4, 0, 0, 0, "f4x4");

    // 2x2 all-negative frame.
    pix[0] = -5; pix[1] = -3; pix[2] = -9; pix[3] = -7; nexp = 1;
`ifdef MAXPOOL_RELU_EN
    exp_arr[0] = 0;
`else
    exp_arr[0] = -3;
`endif
    run_frame(2, 2, 0, 0, 0, "f2x2neg");

    // 4x4 ramp with the first result held back by downstream.
    for (int i = 0; i < 16; i++) pix[i] = i;
    exp_arr[0] = 5; exp_arr[1] = 7; exp_arr[2] = 13; exp_arr[3] = 15; nexp = 4;
    run_frame(4, 4, 0, 0, 1, "stall");

    // Illegal configurations: odd, zero, above MAX_DIM.
    bad_rows[0] = 4;  bad_cols[0] = 3;
    bad_rows[1] = 0;  bad_cols[1] = 4;
    bad_rows[2] = 66; bad_cols[2] = 4;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      start = 1'b1; cfg_rows = 7'(bad_rows[t]); cfg_cols = 7'(bad_cols[t]);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("cfgerr%0d_pulse", t), cfg_err, 1);
      chk($sformatf("cfgerr%0d_busy", t), busy, 0);
      chk($sformatf("cfgerr%0d_rdy", t), bus.in_ready, 0);
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("cfgerr%0d_clear", t), cfg_err, 0);
      chk($sformatf("cfgerr%0d_idle", t), busy, 0);
    end

    // Mid-frame asynchronous reset after 6 samples of an 8x8 frame.
    do_start(8, 8);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 32'(100 + i); bus.out_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_in_ready",  bus.in_ready,  0);
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_out_data",  bus.out_data,  0);
    chk("mrst_busy",      busy,          0);
    chk("mrst_done",      done,          0);
    @(negedge clk);
    rst_n = 1'b1;
    pix[0] = 1; pix[1] = 2; pix[2] = 3; pix[3] = 4;
    exp_arr[0] = 4; nexp = 1;
    run_frame(2, 2, 0, 0, 0, "post_rst");

    // Non-square mixed-sign frame with light gaps.
    for (int i = 0; i < 24; i++) pix[i] = ((i * 37) % 41) - 20;
    build_model(4, 6);
    run_frame(4, 6, 20, 20, 0, "f4x6");

    // Full-size frame, full-range random samples, random gaps both sides.
    for (int i = 0; i < 4096; i++) pix[i] = int'($urandom);
    build_model(64, 64);
    run_frame(64, 64, 25, 25, 0, "f64");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 DATA_W, default `INTERNAL_BITS (32), signed sample width for input and output.
REQ-002 MAX_DIM, default 64, maximum image rows and columns; line buffer depth is MAX_DIM/2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; latches cfg_rows/cfg_cols and begins a frame.
REQ-006 cfg_rows  input  7  frame height in samples; legal values are even, 2..MAX_DIM.
REQ-007 cfg_cols  input  7  frame width in samples; legal values are even, 2..MAX_DIM.
REQ-008 in_valid  input  1  in_data holds a sample (raster order, row-major).
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DATA_W  signed activation sample.
REQ-011 out_valid  output  1  out_data holds a pooled sample.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  DATA_W  signed 2x2 max, stride 2.
REQ-014 busy  output  1  high in state RUN.
REQ-015 done  output  1  one-cycle pulse when the frame's last pooled sample is accepted.
REQ-016 cfg_err  output  1  one-cycle pulse when start is rejected due to illegal cfg.

Function
REQ-017 FSM states are IDLE, RUN and FLUSH; start with legal cfg in IDLE moves to RUN and clears row/col counters.
REQ-018 start with illegal cfg (odd, zero, or >MAX_DIM) pulses cfg_err the next cycle and stays in IDLE; start outside IDLE is ignored.
REQ-019 Handshake: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready.
REQ-020 in_ready = (state==RUN) && !(out_valid && !out_ready).
REQ-021 Even row (0,2,...), even column: the sample is held in a pair register; odd column: max(pair, sample) is written to linebuf[col/2].
REQ-022 Odd row, odd column: out_data is registered as max(pair, sample, linebuf[col/2]), and out_valid rises the cycle after the accepting edge (latency 1).
REQ-023 out_valid and out_data hold stable until accepted; in_valid may deassert at any time without loss.
REQ-024 All comparisons are signed, DATA_W bits wide, with no saturation or truncation.
REQ-025 col wraps to 0 at cfg_cols-1 and row increments; after the last input of row cfg_rows-1 the FSM moves to FLUSH.
REQ-026 FLUSH waits for the final output transfer, pulses done in that same cycle, and returns to IDLE.
REQ-027 Output count per frame is exactly (cfg_rows/2)*(cfg_cols/2).

Reset
REQ-028 rst_n low, at any time including mid-frame, forces IDLE, clears all counters, pair register and output register.
REQ-029 During and after reset: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, cfg_err=0; linebuf contents need not be cleared.

Configuration
REQ-030 Macro MAXPOOL_RELU_EN: when defined, each accepted in_data with bit DATA_W-1 set is replaced by 0 before pooling (fused ReLU), so all outputs are >=0.
REQ-031 Without MAXPOOL_RELU_EN, samples are pooled unmodified and negative outputs are possible.

Verification
REQ-032 4x4 frame with samples 0..15 in raster order, out_ready=1 -> outputs 5,7,13,15, then done pulse; 4 outputs only.
REQ-033 2x2 frame with samples -5,-3,-9,-7 -> output -3 without MAXPOOL_RELU_EN; output 0 with it.
REQ-034 4x4 frame with out_ready held 0 after the first output -> in_ready drops, out_data stays 5 until released; no sample lost.
REQ-035 start with cfg_cols=3 -> cfg_err pulse, busy stays 0, in_ready stays 0.
REQ-036 rst_n asserted after 6 inputs of an 8x8 frame -> all outputs 0 immediately; a new 2x2 frame {1,2,3,4} then yields 4 and done.
REQ-037 64x64 frame with random in_valid/out_ready gaps -> 1024 outputs matching the software 2x2 max model.
